myfunc_sweep_ctrl: RTL

Sequencer that drives the 4-input combinational function block myfunc through all 16 input vectors {a,b,c,d} = 0..15, one vector at a time. After each vector settles for a programmable number of cycles, it samples the function output. Results build up into a 16-bit truth table, which is checked against an expected table. Sits between a host/bench (start/done handshake) and one myfunc instance; replaces hand-written per-vector stimulus sequences.

---
 rtl/myfunc_sweep_ctrl_pkg.sv | 16 +
 rtl/myfunc_sweep_ctrl_settle_counter.sv | 34 +++
 rtl/myfunc_sweep_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/myfunc_sweep_ctrl_pkg.sv
// Shared definitions for the myfunc sweep sequencer: state encoding, last vector index
// and the legal settle range.
package myfunc_sweep_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StHold   = 2'd1,
        StSample = 2'd2,
        StDone   = 2'd3
    } state_t;

    localparam logic [3:0]  VEC_LAST   = 4'd15;
    localparam int unsigned SETTLE_MIN = 1;
    localparam int unsigned SETTLE_MAX = 15;

endpackage

// File: rtl/myfunc_sweep_ctrl_settle_counter.sv
// Loadable down-counter with a zero flag; holds at zero rather than wrapping.
module myfunc_sweep_ctrl_settle_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/myfunc_sweep_ctrl.sv
// Sweeps myfunc through every input vector, builds its truth table and compares it
// against an expected table captured at start.
module myfunc_sweep_ctrl
    import myfunc_sweep_ctrl_pkg::*;
#(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2**N_IN-1:0]   expected,
    input  logic                 func_in,
    output logic [N_IN-1:0]      vec_out,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_out,
    output logic                 mismatch,
    output logic [N_IN-1:0]      fail_idx
);

    localparam logic [N_IN-1:0] VecLast   = N_IN'(VEC_LAST);
    localparam logic [N_IN-1:0] VecOne    = N_IN'(1);
    localparam logic [3:0]      SettleLd  = 4'(SETTLE - 1);

    state_t              state_q, state_d;
    logic [N_IN-1:0]     vec_q, vec_d;
    logic [2**N_IN-1:0]  exp_q, exp_d;
    logic [2**N_IN-1:0]  table_q, table_d;
    logic                mismatch_q, mismatch_d;
    logic [N_IN-1:0]     fail_q, fail_d;
    logic                cnt_load, cnt_dec, cnt_zero;

    myfunc_sweep_ctrl_settle_counter #(
        .W (4)
    ) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (SettleLd),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        exp_d      = exp_q;
        table_d    = table_q;
        mismatch_d = mismatch_q;
        fail_d     = fail_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d    = StHold;
                    exp_d      = expected;
                    table_d    = '0;
                    mismatch_d = 1'b0;
                    fail_d     = '0;
                    vec_d      = '0;
                    cnt_load   = 1'b1;
                end
            end
            StHold: begin
                if (abort) begin
                    state_d = StIdle;
                    vec_d   = '0;
                end else if (cnt_zero) begin
                    state_d = StSample;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StSample: begin
                // An abort in the sample cycle drops the sample entirely.
                if (abort) begin
                    state_d = StIdle;
                    vec_d   = '0;
                end else begin
                    table_d[vec_q] = func_in;
                    if ((func_in != exp_q[vec_q]) && !mismatch_q) begin
                        mismatch_d = 1'b1;
                        fail_d     = vec_q;
                    end
                    if (vec_q == VecLast) begin
                        state_d = StDone;
                    end else begin
                        vec_d    = vec_q + VecOne;
                        cnt_load = 1'b1;
                        state_d  = StHold;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                vec_d   = '0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            vec_q      <= '0;
            exp_q      <= '0;
            table_q    <= '0;
            mismatch_q <= 1'b0;
            fail_q     <= '0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            exp_q      <= exp_d;
            table_q    <= table_d;
            mismatch_q <= mismatch_d;
            fail_q     <= fail_d;
        end
    end

    assign vec_out   = vec_q;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign table_out = table_q;
    assign mismatch  = mismatch_q;
    assign fail_idx  = fail_q;

endmodule
